// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU front end: controller states,
// opcodes and the bit positions inside the 4-bit status word.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_CHG = 2'b11;

  localparam int ST_ERR    = 0;
  localparam int ST_EVEN   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_SINGLE = 3;

endpackage

// File: rtl/ALU.sv
// Shared ALU datapath: operands are registered on every clock, and the result
// and status are decoded combinationally from those registers. Reset is active-low.
module ALU
  import alu_ctrl_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_op,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic [BITS-1:0] o_out,
  output logic [3:0]      o_status
);

  logic [1:0]        op_q;
  logic [BITS-1:0]   a_q;
  logic [BITS-1:0]   b_q;
  logic [2*BITS-1:0] shl_w;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      op_q <= OP_SUB;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      op_q <= i_op;
      a_q  <= i_a;
      b_q  <= i_b;
    end
  end

  // SUB flags a borrow as ERROR; SHL flags an out-of-range shift amount as ERROR
  // and any bits pushed past the top as OVF. CMP yields 1 / 0 / all-ones.
  always_comb begin
    shl_w    = {{BITS{1'b0}}, a_q} << b_q;
    o_out    = '0;
    o_status = '0;
    case (op_q)
      OP_SUB: begin
        o_out            = a_q - b_q;
        o_status[ST_ERR] = (a_q < b_q);
      end
      OP_CMP: begin
        if (a_q > b_q)      o_out = BITS'(1);
        else if (a_q < b_q) o_out = '1;
      end
      OP_SHL: begin
        if (32'(b_q) >= 32'(BITS)) begin
          o_status[ST_ERR] = 1'b1;
        end else begin
          o_out            = shl_w[BITS-1:0];
          o_status[ST_OVF] = |shl_w[2*BITS-1:BITS];
        end
      end
      OP_CHG: o_out = a_q ^ b_q;
    endcase
    o_status[ST_EVEN]   = ~^o_out;
    o_status[ST_SINGLE] = ~|o_out[BITS-1:1];
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select. When both requesters are valid the
// pointer names the one that gets priority; otherwise the lone valid one wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    gnt_o = 2'b00;
    idx_o = 1'b0;
    case (valid_i)
      2'b01: begin
        gnt_o = 2'b01;
        idx_o = 1'b0;
      end
      2'b10: begin
        gnt_o = 2'b10;
        idx_o = 1'b1;
      end
      2'b11: begin
        gnt_o = ptr_i ? 2'b10 : 2'b01;
        idx_o = ptr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU between two requesters and
// returns each result to its own requester, counting erroring results.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [1:0][1:0]      i_req_op,
  input  logic [1:0][BITS-1:0] i_req_a,
  input  logic [1:0][BITS-1:0] i_req_b,
  output logic [1:0]           o_rsp_valid,
  input  logic [1:0]           i_rsp_ready,
  output logic [BITS-1:0]      o_rsp_data,
  output logic [3:0]           o_rsp_status,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_err_cnt
);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            gnt_q, gnt_d;
  logic [1:0]      op_q, op_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] data_q, data_d;
  logic [3:0]      status_q, status_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [1:0]      win_gnt;
  logic            win_idx;
  logic [BITS-1:0] alu_out;
  logic [3:0]      alu_status;

  rr_arb2 u_arb (
    .valid_i (i_req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx)
  );

  ALU #(.BITS(BITS)) u_alu (
    .i_clk    (i_clk),
    .i_rst    (~i_rst),
    .i_op     (op_q),
    .i_a      (a_q),
    .i_b      (b_q),
    .o_out    (alu_out),
    .o_status (alu_status)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      op_q     <= OP_SUB;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      status_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  // LOAD gives the ALU its input-register cycle; its result is only trusted in CAPT.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    status_d    = status_q;
    err_d       = err_q;
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (!i_rst) o_req_ready = win_gnt;
        if (|(i_req_valid & o_req_ready)) begin
          gnt_d   = win_idx;
          op_d    = i_req_op[win_idx];
          a_d     = i_req_a[win_idx];
          b_d     = i_req_b[win_idx];
          state_d = LOAD;
        end
      end
      LOAD: state_d = CAPT;
      CAPT: begin
        data_d   = alu_out;
        status_d = alu_status;
        if (alu_status[ST_ERR] && (err_q != '1)) err_d = err_q + CNT_W'(1);
        state_d  = RESP;
      end
      RESP: begin
        o_rsp_valid[gnt_q] = 1'b1;
        if (i_rsp_ready[gnt_q]) begin
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rsp_data   = data_q;
  assign o_rsp_status = status_q;
  assign o_err_cnt    = err_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model; a second instance has a 2-bit error counter.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] reqValid;
  logic [1:0] reqReady, reqReadySat;
  logic [1:0][1:0] reqOp;
  logic [1:0][7:0] reqA, reqB;
  logic [1:0] rspValid, rspValidSat;
  logic [1:0] rspReady;
  logic [7:0] rspData, rspDataSat;
  logic [3:0] rspStatus, rspStatusSat;
  logic busyO, busySat;
  logic [7:0] errCnt;
  logic [1:0] errCntSat;

  int nChecks = 0;
  int nFails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.BITS(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_op(reqOp), .i_req_a(reqA), .i_req_b(reqB),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_data(rspData), .o_rsp_status(rspStatus),
    .o_busy(busyO), .o_err_cnt(errCnt)
  );

  alu_arbiter #(.BITS(8), .CNT_W(2)) dutSat (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReadySat),
    .i_req_op(reqOp), .i_req_a(reqA), .i_req_b(reqB),
    .o_rsp_valid(rspValidSat), .i_rsp_ready(rspReady),
    .o_rsp_data(rspDataSat), .o_rsp_status(rspStatusSat),
    .o_busy(busySat), .o_err_cnt(errCntSat)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ALU result and status from plain integer arithmetic on 8-bit operands.
  function automatic void aluModel(input int op, input int a, input int b, output int res, output int st);
    int err, ovf, ones, full;
    err = 0; ovf = 0; ones = 0; res = 0; full = 0;
    case (op)
      0: begin res = (a - b + 256) % 256; err = (a < b) ? 1 : 0; end
      1: res = (a > b) ? 1 : ((a == b) ? 0 : 255);
      2: begin
        if (b >= 8) err = 1;
        else begin full = a * (1 << b); res = full % 256; ovf = (full >= 256) ? 1 : 0; end
      end
      default: res = a ^ b;
    endcase
    for (int i = 0; i < 8; i++) ones += (res >> i) & 1;
    st = err + 2 * (((ones % 2) == 0) ? 1 : 0) + 4 * ovf + 8 * ((res < 2) ? 1 : 0);
  endfunction

  function automatic int modelWinner(input logic [1:0] v, input int ptr);
    if (v == 2'b11) return ptr;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Model state: a transaction accepted at age 0 shows its result from age 3 on.
  bit mLive = 0;
  bit mBusy = 0;
  int mGnt, mAge, mOp, mA, mB, mPtr, mData, mStatus, mErr8, mErr2;
  int expWin, expReady, expRspValid, mRes, mSt;

  always @(negedge clk) begin
    expWin = modelWinner(reqValid, mPtr);
    if (mLive) begin
      expReady    = (!mBusy && !rst && expWin >= 0) ? (1 << expWin) : 0;
      expRspValid = (mBusy && mAge >= 3) ? (1 << mGnt) : 0;
      checkOutput("req_ready", 32'(reqReady), expReady);
      checkOutput("rsp_valid", 32'(rspValid), expRspValid);
      checkOutput("rsp_data", 32'(rspData), mData);
      checkOutput("rsp_status", 32'(rspStatus), mStatus);
      checkOutput("busy", 32'(busyO), 32'(mBusy));
      checkOutput("err_cnt", 32'(errCnt), mErr8);
      checkOutput("sat_rsp_valid", 32'(rspValidSat), expRspValid);
      checkOutput("sat_rsp_data", 32'(rspDataSat), mData);
      checkOutput("sat_err_cnt", 32'(errCntSat), mErr2);
    end
    if (rst) begin
      mLive = 1; mBusy = 0; mPtr = 0; mData = 0; mStatus = 0;
      mErr8 = 0; mErr2 = 0; mAge = 0; mGnt = 0;
    end else if (mLive) begin
      if (!mBusy) begin
        if (expWin >= 0) begin
          mBusy = 1; mGnt = expWin; mAge = 1;
          mOp = int'(reqOp[expWin]); mA = int'(reqA[expWin]); mB = int'(reqB[expWin]);
        end
      end else if (mAge >= 3) begin
        if (rspReady[mGnt]) begin mBusy = 0; mPtr = 1 - mGnt; end
      end else begin
        mAge++;
        if (mAge == 3) begin
          aluModel(mOp, mA, mB, mRes, mSt);
          mData = mRes; mStatus = mSt;
          if (mSt % 2 == 1) begin
            if (mErr8 < 255) mErr8++;
            if (mErr2 < 3) mErr2++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic setReq(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    reqOp[r] = op;
    reqA[r]  = a;
    reqB[r]  = b;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      step();
      if (!busyO) break;
    end
    checkOutput("idle_timeout", 32'(busyO), 0);
  endtask

  task automatic runOp(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int got;
    got = 0;
    setReq(r, op, a, b);
    reqValid = (r == 0) ? 2'b01 : 2'b10;
    rspReady = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (reqReady[r]) got = 1;
      step();
      if (got == 1) break;
    end
    reqValid = 2'b00;
    checkOutput("accept_timeout", 32'(got), 1);
    waitIdle();
  endtask

  task automatic applyStimulus();
    reqValid = 2'($urandom);
    rspReady = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      reqOp[i] = 2'($urandom);
      reqA[i]  = 8'($urandom);
      reqB[i]  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 9));
    end
    rst = ($urandom_range(0, 63) == 0);
    step();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reqValid = 2'b11;
    rspReady = 2'b00;
    setReq(0, OP_SUB, 8'd0, 8'd0);
    setReq(1, OP_SUB, 8'd0, 8'd0);
    step();
    step();
    #1;
    checkOutput("reset_ready", 32'(reqReady), 0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 0);
    checkOutput("reset_busy", 32'(busyO), 0);
    checkOutput("reset_data", 32'(rspData), 0);
    checkOutput("reset_status", 32'(rspStatus), 0);
    checkOutput("reset_err", 32'(errCnt), 0);

    $display("[TB] single request");
    rst = 1'b0;
    reqValid = 2'b01;
    setReq(0, OP_SUB, 8'd5, 8'd3);
    #1;
    checkOutput("single_ready", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    step();
    step();
    #1;
    checkOutput("single_rsp_valid", 32'(rspValid), 32'h1);
    checkOutput("single_data", 32'(rspData), 32'h02);
    checkOutput("single_status", 32'(rspStatus), 32'h0);
    rspReady = 2'b01;
    step();
    reqValid = 2'b11;
    setReq(1, OP_CHG, 8'hA5, 8'hFF);
    #1;
    checkOutput("ptr_after_single", 32'(reqReady), 32'h2);
    step();
    reqValid = 2'b00;
    rspReady = 2'b11;
    waitIdle();

    $display("[TB] simultaneous requests");
    doReset();
    reqValid = 2'b11;
    rspReady = 2'b11;
    setReq(0, OP_SUB, 8'd40, 8'd2);
    setReq(1, OP_SHL, 8'h81, 8'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("rr_order", 32'(reqReady), (k % 2 == 0) ? 32'h1 : 32'h2);
      repeat (4) step();
    end
    reqValid = 2'b00;
    waitIdle();

    $display("[TB] response back-pressure");
    setReq(0, OP_CHG, 8'h3C, 8'h0F);
    reqValid = 2'b01;
    rspReady = 2'b00;
    step();
    reqValid = 2'b00;
    step();
    step();
    rspReady = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_valid", 32'(rspValid), 32'h1);
      checkOutput("bp_data", 32'(rspData), 32'h33);
      step();
    end
    rspReady = 2'b01;
    step();
    #1;
    checkOutput("bp_release", 32'(busyO), 0);

    $display("[TB] error counter");
    doReset();
    runOp(0, OP_SUB, 8'd1, 8'd2);
    runOp(0, OP_SUB, 8'd0, 8'd9);
    runOp(0, OP_SHL, 8'd1, 8'd9);
    runOp(0, OP_CMP, 8'd3, 8'd3);
    checkOutput("err_three", 32'(errCnt), 3);
    checkOutput("sat_err_three", 32'(errCntSat), 3);
    runOp(0, OP_SUB, 8'd2, 8'd200);
    runOp(0, OP_SHL, 8'd5, 8'd8);
    checkOutput("err_five", 32'(errCnt), 5);
    checkOutput("sat_err_hold", 32'(errCntSat), 3);

    $display("[TB] reset mid-operation");
    setReq(1, OP_SUB, 8'd1, 8'd7);
    reqValid = 2'b10;
    #1;
    checkOutput("pre_rst_ready", 32'(reqReady), 32'h2);
    step();
    reqValid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_load_busy", 32'(busyO), 0);
    checkOutput("rst_load_err", 32'(errCnt), 0);
    checkOutput("rst_load_sat_err", 32'(errCntSat), 0);
    reqValid = 2'b11;
    rspReady = 2'b00;
    setReq(0, OP_SUB, 8'd0, 8'd1);
    #1;
    checkOutput("rst_ptr", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    step();
    step();
    #1;
    checkOutput("pre_rst_resp", 32'(rspValid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_resp_valid", 32'(rspValid), 0);
    checkOutput("rst_resp_busy", 32'(busyO), 0);
    rspReady = 2'b11;
    repeat (6) step();

    $display("[TB] withdrawn request");
    setReq(0, OP_CMP, 8'd9, 8'd4);
    setReq(1, OP_SUB, 8'd8, 8'd1);
    reqValid = 2'b01;
    rspReady = 2'b00;
    step();
    reqValid = 2'b00;
    step();
    step();
    reqValid = 2'b10;
    #1;
    checkOutput("withdraw_ready", 32'(reqReady), 0);
    step();
    reqValid = 2'b00;
    rspReady = 2'b01;
    step();
    repeat (6) step();
    checkOutput("withdraw_idle", 32'(busyO), 0);

    $display("[TB] random traffic");
    repeat (400) applyStimulus();
    rst = 1'b0;
    reqValid = 2'b00;
    rspReady = 2'b11;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
